// File: rtl/mem_stage_varlat_if.sv
// Signal bundle around the MEM stage: EXE offer, data-SRAM response, flush, WB offer and ID forwarding view.
interface mem_stage_varlat_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_alu_result;
    logic            in_res_from_mem;
    logic [2:0]      in_mem_op;
    logic            in_req_sent;
    logic            in_gr_we;
    logic [4:0]      in_dest;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            data_data_ok;
    logic [XLEN-1:0] data_rdata;
    logic            flush;
    logic            flush_exe_req;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_gr_we;
    logic [4:0]      out_dest;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            fwd_valid;
    logic [4:0]      fwd_dest;
    logic            fwd_blocked;

    modport slave (
        input  in_valid, in_alu_result, in_res_from_mem, in_mem_op, in_req_sent,
               in_gr_we, in_dest, in_pc, in_inst, data_data_ok, data_rdata,
               flush, flush_exe_req, out_ready,
        output in_ready, out_valid, out_result, out_gr_we, out_dest, out_pc,
               out_inst, fwd_valid, fwd_dest, fwd_blocked
    );

    modport master (
        output in_valid, in_alu_result, in_res_from_mem, in_mem_op, in_req_sent,
               in_gr_we, in_dest, in_pc, in_inst, data_data_ok, data_rdata,
               flush, flush_exe_req, out_ready,
        input  in_ready, out_valid, out_result, out_gr_we, out_dest, out_pc,
               out_inst, fwd_valid, fwd_dest, fwd_blocked
    );
endinterface

// File: rtl/mem_stage_varlat.sv
// MEM pipeline stage waiting on a variable-latency data SRAM: response buffering, load
// extension, flush with orphaned-response cancellation, and a hazard view for ID.
module mem_stage_varlat #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DISC_W = 2
) (
    input logic              clk,
    input logic              reset,
    mem_stage_varlat_if.slave bus
);
    localparam int unsigned LANE_W = (XLEN == 64) ? 3 : 2;
    localparam int unsigned CNT_W  = DISC_W + 2;
    localparam logic [DISC_W-1:0] DISC_MAX = '1;

    logic              valid;
    logic              buf_valid;
    logic [DISC_W-1:0] disc_cnt;
    logic [XLEN-1:0]   buf_data;
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   pc_q;
    logic              rfm_q;
    logic              req_q;
    logic              we_q;
    logic [2:0]        op_q;
    logic [4:0]        dest_q;
    logic [31:0]       inst_q;

    logic              need_data;
    logic              live_ok;
    logic              ready_go;
    logic              in_rdy;
    logic              out_vld;
    logic              out_hs;
    logic              accept;
    logic              old_owes;
    logic              new_owes;
    logic              capture;
    logic              new_capture;
    logic [CNT_W-1:0]  disc_sum;
    logic [DISC_W-1:0] disc_nxt;

    // Handshake and response ownership
    always_comb begin
        need_data   = rfm_q & req_q;
        live_ok     = bus.data_data_ok & (disc_cnt == '0);
        ready_go    = ~need_data | buf_valid | live_ok;
        old_owes    = valid & need_data & ~buf_valid;
        out_vld     = valid & ready_go & ~bus.flush;
        out_hs      = out_vld & bus.out_ready;
        in_rdy      = ~valid | (ready_go & bus.out_ready) | bus.flush;
        accept      = bus.in_valid & in_rdy & ~bus.flush;
        new_owes    = accept & bus.in_res_from_mem & bus.in_req_sent;
        capture     = live_ok & old_owes & ~out_hs;
        // A response not claimed by the departing occupant belongs to the incoming load.
        new_capture = live_ok & ~old_owes & new_owes;
    end

    // Orphaned-response counter: one per cancelled owed response, saturating
    always_comb begin
        disc_sum = CNT_W'(disc_cnt);
        if (bus.data_data_ok && (disc_cnt != '0)) begin
            disc_sum = disc_sum - CNT_W'(1);
        end
        if (bus.flush) begin
            disc_sum = disc_sum + CNT_W'(old_owes & ~live_ok) + CNT_W'(bus.flush_exe_req);
        end
        disc_nxt = (disc_sum > CNT_W'(DISC_MAX)) ? DISC_MAX : DISC_W'(disc_sum);
    end

    // Load extension
    logic [XLEN-1:0]     ext_src;
    logic [LANE_W+2:0]   shamt;
    logic [15:0]         lo16;
    logic [XLEN-1:0]     word_val;
    logic [XLEN-1:0]     wu_val;
    logic [XLEN-1:0]     dw_val;
    logic [XLEN-1:0]     load_val;

    assign ext_src = need_data ? (buf_valid ? buf_data : bus.data_rdata) : alu_q;
    assign shamt   = {alu_q[LANE_W-1:0], 3'b000};
    assign lo16    = 16'(ext_src >> shamt);

    if (XLEN == 64) begin : g_ld64
        logic [31:0] lo32;
        assign lo32     = 32'(ext_src >> shamt);
        assign word_val = {{32{lo32[31]}}, lo32};
        assign wu_val   = {32'b0, lo32};
        assign dw_val   = ext_src >> shamt;
    end else begin : g_ld32
        assign word_val = ext_src;
        assign wu_val   = ext_src;
        assign dw_val   = ext_src;
    end

    always_comb begin
        load_val = word_val;
        case (op_q)
            3'b001:  load_val = {{(XLEN-8){lo16[7]}}, lo16[7:0]};
            3'b010:  load_val = {{(XLEN-16){lo16[15]}}, lo16};
            3'b011:  load_val = {{(XLEN-8){1'b0}}, lo16[7:0]};
            3'b100:  load_val = {{(XLEN-16){1'b0}}, lo16};
            3'b101:  load_val = wu_val;
            3'b110:  load_val = dw_val;
            default: load_val = word_val;
        endcase
    end

    // Occupant, buffer and counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= 1'b0;
            buf_valid <= 1'b0;
            disc_cnt  <= '0;
            buf_data  <= '0;
            alu_q     <= '0;
            pc_q      <= '0;
            rfm_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            op_q      <= '0;
            dest_q    <= '0;
            inst_q    <= '0;
        end else begin
            disc_cnt <= disc_nxt;
            if (bus.flush) begin
                valid     <= 1'b0;
                buf_valid <= 1'b0;
            end else if (accept) begin
                valid     <= 1'b1;
                buf_valid <= new_capture;
                if (new_capture) buf_data <= bus.data_rdata;
                alu_q     <= bus.in_alu_result;
                pc_q      <= bus.in_pc;
                rfm_q     <= bus.in_res_from_mem;
                req_q     <= bus.in_req_sent;
                we_q      <= bus.in_gr_we;
                op_q      <= bus.in_mem_op;
                dest_q    <= bus.in_dest;
                inst_q    <= bus.in_inst;
            end else if (out_hs) begin
                valid     <= 1'b0;
                buf_valid <= 1'b0;
            end else if (capture) begin
                buf_valid <= 1'b1;
                buf_data  <= bus.data_rdata;
            end
        end
    end

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_vld;
    assign bus.out_result  = rfm_q ? load_val : alu_q;
    assign bus.out_gr_we   = we_q;
    assign bus.out_dest    = dest_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_inst    = inst_q;
    assign bus.fwd_valid   = valid & we_q;
    assign bus.fwd_dest    = dest_q;
    assign bus.fwd_blocked = valid & rfm_q & ~ready_go;

    // A response nobody owes and nothing cancels is a protocol error upstream
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_no_stray_ok: assert (!(bus.data_data_ok && (disc_cnt == '0) && !old_owes && !new_owes))
                else $error("mem_stage_varlat: data_ok with no owing occupant");
        end
    end
endmodule

// File: tb/tb_mem_stage_varlat.sv
// Bench for mem_stage_varlat: directed load vectors (XLEN 32 and 64), buffering, flush and
// async reset sequences, then random traffic against a transaction-level scoreboard.
module tb_mem_stage_varlat;
    logic clk = 1'b0;
    logic reset;

    mem_stage_varlat_if #(.XLEN(32)) if32 ();
    mem_stage_varlat_if #(.XLEN(64)) if64 ();

    mem_stage_varlat #(.XLEN(32), .DISC_W(2)) u32 (.clk(clk), .reset(reset), .bus(if32));
    mem_stage_varlat #(.XLEN(64), .DISC_W(2)) u64 (.clk(clk), .reset(reset), .bus(if64));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        ov;
        logic        ir;
        logic        fv;
        logic        fb;
        logic        we;
        logic [4:0]  fd;
        logic [4:0]  od;
        logic [63:0] res;
        logic [63:0] pc;
        logic [31:0] inst;
    } obs_t;

    typedef struct {
        int          x;
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] rdata;
        int          lat;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic obs_t observe(int x);
        obs_t o;
        if (x == 64) begin
            o = '{if64.out_valid, if64.in_ready, if64.fwd_valid, if64.fwd_blocked, if64.out_gr_we,
                  if64.fwd_dest, if64.out_dest, if64.out_result, if64.out_pc, if64.out_inst};
        end else begin
            o = '{if32.out_valid, if32.in_ready, if32.fwd_valid, if32.fwd_blocked, if32.out_gr_we,
                  if32.fwd_dest, if32.out_dest, {32'b0, if32.out_result}, {32'b0, if32.out_pc},
                  if32.out_inst};
        end
        return o;
    endfunction

    task automatic set_in(int x, logic v, logic rfm, logic [2:0] op, logic rs, logic [63:0] alu,
                          logic we, logic [4:0] dst);
        logic [63:0] pc;
        logic [31:0] inst;
        pc   = alu + 64'h100;
        inst = 32'hA5A5_0000 | {27'b0, dst};
        if (x == 64) begin
            if64.in_valid = v; if64.in_res_from_mem = rfm; if64.in_mem_op = op;
            if64.in_req_sent = rs; if64.in_alu_result = alu; if64.in_gr_we = we;
            if64.in_dest = dst; if64.in_pc = pc; if64.in_inst = inst;
        end else begin
            if32.in_valid = v; if32.in_res_from_mem = rfm; if32.in_mem_op = op;
            if32.in_req_sent = rs; if32.in_alu_result = alu[31:0]; if32.in_gr_we = we;
            if32.in_dest = dst; if32.in_pc = pc[31:0]; if32.in_inst = inst;
        end
    endtask

    task automatic set_valid(int x, logic v);
        if (x == 64) if64.in_valid = v; else if32.in_valid = v;
    endtask

    task automatic set_resp(int x, logic ok, logic [63:0] d);
        if (x == 64) begin if64.data_data_ok = ok; if64.data_rdata = d; end
        else begin if32.data_data_ok = ok; if32.data_rdata = d[31:0]; end
    endtask

    task automatic set_ctl(int x, logic ordy, logic fl, logic fer);
        if (x == 64) begin if64.out_ready = ordy; if64.flush = fl; if64.flush_exe_req = fer; end
        else begin if32.out_ready = ordy; if32.flush = fl; if32.flush_exe_req = fer; end
    endtask

    task automatic idle_all();
        for (int x = 32; x <= 64; x += 32) begin
            set_in(x, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0, 5'd0);
            set_resp(x, 1'b0, 64'd0);
            set_ctl(x, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Expected load value from the lane/op rules, on a 64-bit canvas
    function automatic logic [63:0] ref_load(int x, logic [2:0] op, logic [63:0] addr, logic [63:0] d);
        logic [63:0] s, w, r;
        int sh;
        sh = (x == 64) ? int'(addr[2:0]) * 8 : int'(addr[1:0]) * 8;
        s  = d >> sh;
        w  = (x == 32) ? {32'b0, d[31:0]} : {{32{s[31]}}, s[31:0]};
        case (op)
            3'd1:    r = {{56{s[7]}}, s[7:0]};
            3'd2:    r = {{48{s[15]}}, s[15:0]};
            3'd3:    r = {56'b0, s[7:0]};
            3'd4:    r = {48'b0, s[15:0]};
            3'd5:    r = (x == 64) ? {32'b0, s[31:0]} : w;
            3'd6:    r = (x == 64) ? s : w;
            default: r = w;
        endcase
        return (x == 32) ? (r & 64'hFFFF_FFFF) : r;
    endfunction

    task automatic run_vec(vec_t v, int idx);
        obs_t o;
        @(negedge clk);
        set_in(v.x, 1'b1, 1'b1, v.op, 1'b1, v.addr, 1'b1, 5'd7);
        set_ctl(v.x, 1'b1, 1'b0, 1'b0);
        #1 o = observe(v.x);
        chk($sformatf("vec%0d_accept", idx), 64'(o.ir), 64'd1);
        @(negedge clk);
        set_valid(v.x, 1'b0);
        for (int i = 0; i < v.lat; i++) begin
            #1 o = observe(v.x);
            chk($sformatf("vec%0d_blocked", idx), 64'(o.fb), 64'd1);
            chk($sformatf("vec%0d_wait_ov", idx), 64'(o.ov), 64'd0);
            @(negedge clk);
        end
        set_resp(v.x, 1'b1, v.rdata);
        #1 o = observe(v.x);
        chk($sformatf("vec%0d_ov", idx), 64'(o.ov), 64'd1);
        chk($sformatf("vec%0d_unblocked", idx), 64'(o.fb), 64'd0);
        chk($sformatf("vec%0d_result", idx), o.res, v.exp);
        @(negedge clk);
        set_resp(v.x, 1'b0, 64'd0);
        #1 o = observe(v.x);
        chk($sformatf("vec%0d_drained", idx), 64'(o.ov), 64'd0);
    endtask

    // Random-phase scoreboard state
    bit          occ, occ_load, occ_need, occ_have, occ_we;
    logic [4:0]  occ_dest;
    logic [63:0] occ_res, occ_pc;
    logic [31:0] occ_inst;
    bit          q_live[$];
    logic [31:0] q_data[$];

    initial begin
        vec_t vecs[11];
        obs_t o;

        vecs[0]  = '{32, 3'd1, 64'h3,  64'h80FF_0000, 2, 64'hFFFF_FF80};
        vecs[1]  = '{32, 3'd4, 64'h2,  64'h80FF_0000, 2, 64'h0000_80FF};
        vecs[2]  = '{32, 3'd0, 64'h1,  64'h1234_5678, 0, 64'h1234_5678};
        vecs[3]  = '{32, 3'd2, 64'h0,  64'h0000_8001, 1, 64'hFFFF_8001};
        vecs[4]  = '{32, 3'd3, 64'h1,  64'h0000_9A00, 3, 64'h0000_009A};
        vecs[5]  = '{32, 3'd6, 64'h2,  64'hCAFE_BABE, 0, 64'hCAFE_BABE};
        vecs[6]  = '{64, 3'd0, 64'h4,  64'h8000_0001_0000_0000, 1, 64'hFFFF_FFFF_8000_0001};
        vecs[7]  = '{64, 3'd6, 64'h0,  64'h8000_0001_0000_0000, 1, 64'h8000_0001_0000_0000};
        vecs[8]  = '{64, 3'd5, 64'h4,  64'h8000_0001_0000_0000, 0, 64'h0000_0000_8000_0001};
        vecs[9]  = '{64, 3'd1, 64'h7,  64'h8000_0001_0000_0000, 2, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[10] = '{64, 3'd7, 64'h0,  64'h0000_0000_F000_0000, 0, 64'hFFFF_FFFF_F000_0000};

        // Reset state
        idle_all();
        reset = 1'b1;
        @(posedge clk);
        #1 o = observe(32);
        chk("rst_out_valid", 64'(o.ov), 64'd0);
        chk("rst_in_ready", 64'(o.ir), 64'd1);
        chk("rst_fwd_valid", 64'(o.fv), 64'd0);
        chk("rst_fwd_blocked", 64'(o.fb), 64'd0);
        chk("rst_out_result", o.res, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU ops back to back at full throughput
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            set_in(32, (i < 4), 1'b0, 3'd0, 1'b0, 64'h1234 + 64'(i), 1'b1, 5'(5 + i));
            set_ctl(32, 1'b1, 1'b0, 1'b0);
            #1 o = observe(32);
            chk("alu_in_ready", 64'(o.ir), 64'd1);
            if (i > 0) begin
                chk("alu_out_valid", 64'(o.ov), 64'd1);
                chk("alu_result", o.res, 64'h1234 + 64'(i - 1));
                chk("alu_fwd_valid", 64'(o.fv), 64'd1);
                chk("alu_fwd_dest", 64'(o.fd), 64'(5 + i - 1));
            end
        end
        @(negedge clk);
        #1 o = observe(32);
        chk("alu_drained", 64'(o.ov), 64'd0);

        foreach (vecs[k]) run_vec(vecs[k], k);

        // Response arrives while WB stalls; buffered value must survive changing rdata
        @(negedge clk);
        set_in(32, 1'b1, 1'b1, 3'd0, 1'b1, 64'h40, 1'b1, 5'd9);
        set_ctl(32, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_valid(32, 1'b0);
        set_resp(32, 1'b1, 64'hDEAD_BEEF);
        #1 o = observe(32);
        chk("buf_first_ov", 64'(o.ov), 64'd1);
        chk("buf_first_fb", 64'(o.fb), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_resp(32, 1'b0, 64'($urandom()));
            #1 o = observe(32);
            chk("buf_hold_ov", 64'(o.ov), 64'd1);
            chk("buf_hold_result", o.res, 64'hDEAD_BEEF);
            chk("buf_hold_in_ready", 64'(o.ir), 64'd0);
            chk("buf_hold_valid", 64'(u32.buf_valid), 64'd1);
        end
        @(negedge clk);
        set_ctl(32, 1'b1, 1'b0, 1'b0);
        #1 o = observe(32);
        chk("buf_release_result", o.res, 64'hDEAD_BEEF);
        chk("buf_release_in_ready", 64'(o.ir), 64'd1);
        @(negedge clk);
        #1 o = observe(32);
        chk("buf_drained", 64'(o.ov), 64'd0);

        // Flush a waiting load plus an EXE request: two responses must be dropped
        @(negedge clk);
        set_in(32, 1'b1, 1'b1, 3'd0, 1'b1, 64'h80, 1'b1, 5'd3);
        @(negedge clk);
        set_valid(32, 1'b0);
        set_ctl(32, 1'b1, 1'b1, 1'b1);
        #1 o = observe(32);
        chk("flush_out_valid", 64'(o.ov), 64'd0);
        chk("flush_in_ready", 64'(o.ir), 64'd1);
        @(negedge clk);
        set_ctl(32, 1'b1, 1'b0, 1'b0);
        set_in(32, 1'b1, 1'b1, 3'd0, 1'b1, 64'hC0, 1'b1, 5'd4);
        #1 chk("flush_disc_cnt", 64'(u32.disc_cnt), 64'd2);
        chk("flush_fwd_valid", 64'(observe(32).fv), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_valid(32, 1'b0);
            set_resp(32, 1'b1, 64'h1111_0000 + 64'(i));
            #1 o = observe(32);
            chk("flush_drop_ov", 64'(o.ov), 64'd0);
            chk("flush_drop_fb", 64'(o.fb), 64'd1);
        end
        @(negedge clk);
        set_resp(32, 1'b1, 64'h5A5A_A5A5);
        #1 o = observe(32);
        chk("flush_after_ov", 64'(o.ov), 64'd1);
        chk("flush_after_result", o.res, 64'h5A5A_A5A5);
        @(negedge clk);
        set_resp(32, 1'b0, 64'd0);

        // Asynchronous reset while a load waits and one response is still to be cancelled
        set_in(32, 1'b1, 1'b1, 3'd0, 1'b1, 64'h100, 1'b1, 5'd6);
        @(negedge clk);
        set_valid(32, 1'b0);
        set_ctl(32, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_ctl(32, 1'b1, 1'b0, 1'b0);
        set_in(32, 1'b1, 1'b1, 3'd0, 1'b1, 64'h104, 1'b1, 5'd6);
        @(negedge clk);
        set_valid(32, 1'b0);
        #1 chk("rstw_disc_before", 64'(u32.disc_cnt), 64'd1);
        chk("rstw_fb_before", 64'(observe(32).fb), 64'd1);
        #1 reset = 1'b1;
        #1 o = observe(32);
        chk("rstw_out_valid", 64'(o.ov), 64'd0);
        chk("rstw_in_ready", 64'(o.ir), 64'd1);
        chk("rstw_fwd_blocked", 64'(o.fb), 64'd0);
        chk("rstw_disc_cnt", 64'(u32.disc_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_all();

        // Random traffic against the scoreboard
        occ = 0; occ_load = 0; occ_need = 0; occ_have = 0; occ_we = 0;
        for (int c = 0; c < 1500; c++) begin
            bit deliver, dlive, fl, fer, ordy, iv, rdy, e_ov, e_ir;
            int ndrop, add;
            logic rfm, rs, we;
            logic [2:0] op;
            logic [31:0] alu, rd, rdat;
            logic [4:0] dst;

            @(negedge clk);
            deliver = (q_live.size() > 0) && ($urandom_range(0, 2) == 0);
            dlive   = deliver && q_live[0];
            ndrop   = 0;
            foreach (q_live[k]) if (!q_live[k]) ndrop++;
            if (deliver && !q_live[0]) ndrop--;
            fer  = 1'($urandom_range(0, 1));
            add  = ((occ && occ_need && !occ_have && !dlive) ? 1 : 0) + (fer ? 1 : 0);
            fl   = ($urandom_range(0, 11) == 0) && (ndrop + add <= 3);
            if (!fl) fer = 1'b0;
            ordy = ($urandom_range(0, 3) != 0);
            iv   = 1'($urandom_range(0, 1));
            rfm  = 1'($urandom_range(0, 1));
            rs   = ($urandom_range(0, 4) != 0);
            op   = 3'($urandom_range(0, 7));
            alu  = $urandom();
            we   = 1'($urandom_range(0, 1));
            dst  = 5'($urandom_range(0, 31));
            rd   = deliver ? q_data[0] : $urandom();

            set_in(32, iv, rfm, op, rs, {32'b0, alu}, we, dst);
            set_resp(32, deliver, {32'b0, rd});
            set_ctl(32, ordy, fl, fer);
            #1 o = observe(32);

            rdy  = !occ_need || occ_have || dlive;
            e_ov = occ && rdy && !fl;
            e_ir = !occ || (rdy && ordy) || fl;
            chk("rnd_out_valid", 64'(o.ov), 64'(e_ov));
            chk("rnd_in_ready", 64'(o.ir), 64'(e_ir));
            chk("rnd_fwd_valid", 64'(o.fv), 64'(occ && occ_we));
            chk("rnd_fwd_blocked", 64'(o.fb), 64'(occ && occ_load && !rdy));
            if (occ) chk("rnd_fwd_dest", 64'(o.fd), 64'(occ_dest));
            if (e_ov) begin
                chk("rnd_result", o.res, occ_res);
                chk("rnd_gr_we", 64'(o.we), 64'(occ_we));
                chk("rnd_dest", 64'(o.od), 64'(occ_dest));
                chk("rnd_pc", o.pc, occ_pc);
                chk("rnd_inst", 64'(o.inst), 64'(occ_inst));
            end

            if (deliver) begin
                void'(q_live.pop_front());
                void'(q_data.pop_front());
                if (dlive) occ_have = 1'b1;
            end
            if (fl) begin
                foreach (q_live[k]) q_live[k] = 1'b0;
                occ = 1'b0;
                if (fer) begin
                    q_live.push_back(1'b0);
                    q_data.push_back($urandom());
                end
            end else begin
                if (e_ov && ordy) occ = 1'b0;
                if (iv && e_ir) begin
                    occ      = 1'b1;
                    occ_load = rfm;
                    occ_need = rfm && rs;
                    occ_have = 1'b0;
                    occ_we   = we;
                    occ_dest = dst;
                    occ_pc   = {32'b0, alu + 32'h100};
                    occ_inst = 32'hA5A5_0000 | {27'b0, dst};
                    if (occ_need) begin
                        rdat = $urandom();
                        q_live.push_back(1'b1);
                        q_data.push_back(rdat);
                        occ_res = ref_load(32, op, {32'b0, alu}, {32'b0, rdat});
                    end else if (rfm) begin
                        occ_res = ref_load(32, op, {32'b0, alu}, {32'b0, alu});
                    end else begin
                        occ_res = {32'b0, alu};
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
